// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline run/step/halt controller.
// State encodings are fixed because state_o exposes them.
package pipeline_ctrl_pkg;

    localparam int STATE_W          = 3;
    localparam int DRAIN_CYCLES_DEF = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    // A zero-length drain would never let the halt reach write-back
    function automatic int eff_drain(input int n);
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/pipe_cycle_counter.sv
// Saturating counter of advancing pipeline cycles.
// Synchronous active-low reset.
module pipe_cycle_counter #(
    parameter int NB = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    output logic [NB-1:0] count
);

    logic [NB-1:0] r_count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count <= '0;
        end else if (enable && (r_count != '1)) begin
            r_count <= r_count + NB'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline run/step/halt controller with halt drain and cycle counter.
// Define PIPE_CTRL_CYCLE_CNT_EN to build the saturating cycle counter.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int NB_CYCLES    = 32,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 run_req_i,
    input  logic                 step_req_i,
    input  logic                 halt_detected_i,
    input  logic                 mem_busy_i,
    output logic                 en_pipeline_o,
    output logic [STATE_W-1:0]   state_o,
    output logic                 halted_o,
    output logic                 step_done_o,
    output logic [NB_CYCLES-1:0] cycle_count_o
);

    localparam int DC_EFF = eff_drain(DRAIN_CYCLES);
    localparam int DW     = $clog2(DC_EFF + 1);
    localparam logic [DW-1:0] DC_LOAD = DW'(DC_EFF);

    state_t        r_state;
    state_t        w_next_state;
    logic [DW-1:0] r_drain;
    logic [DW-1:0] w_drain_next;
    logic          r_step_done;
    logic          w_step_done_next;
    logic          w_en;

    assign w_en = ((r_state == ST_RUN) ||
                   (r_state == ST_STEP) ||
                   (r_state == ST_DRAIN)) && !mem_busy_i;

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            r_state     <= ST_IDLE;
            r_drain     <= '0;
            r_step_done <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_drain     <= w_drain_next;
            r_step_done <= w_step_done_next;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_drain_next     = r_drain;
        w_step_done_next = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (run_req_i) begin
                    w_next_state = ST_RUN;
                end else if (step_req_i) begin
                    w_next_state = ST_STEP;
                end
            end
            ST_RUN: begin
                if (w_en && halt_detected_i) begin
                    w_next_state = ST_DRAIN;
                    w_drain_next = DC_LOAD;
                end
            end
            ST_STEP: begin
                if (w_en) begin
                    if (halt_detected_i) begin
                        w_next_state = ST_DRAIN;
                        w_drain_next = DC_LOAD;
                    end else begin
                        w_next_state     = ST_IDLE;
                        w_step_done_next = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_en) begin
                    w_drain_next = r_drain - DW'(1);
                    if (r_drain == DW'(1)) begin
                        w_next_state = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                w_next_state = ST_HALTED;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign en_pipeline_o = w_en;
    assign state_o       = r_state;
    assign halted_o      = (r_state == ST_HALTED);
    assign step_done_o   = r_step_done;

`ifdef PIPE_CTRL_CYCLE_CNT_EN
    pipe_cycle_counter #(
        .NB(NB_CYCLES)
    ) u_cycle_counter (
        .clock  (clock_i),
        .reset  (reset_i),
        .enable (w_en),
        .count  (cycle_count_o)
    );
`else
    assign cycle_count_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: default DUT and a 4-bit-counter,
// zero-drain DUT share stimulus; a behavioural model predicts each cycle.
module tb_pipeline_ctrl;

    logic clk;
    logic rst_n;
    logic run_req;
    logic step_req;
    logic halt_det;
    logic mem_busy;

    logic        en_a;
    logic [2:0]  st_a;
    logic        hl_a;
    logic        sd_a;
    logic [31:0] cnt_a;

    logic        en_b;
    logic [2:0]  st_b;
    logic        hl_b;
    logic        sd_b;
    logic [3:0]  cnt_b;

    pipeline_ctrl u_dut_a (
        .clock_i         (clk),
        .reset_i         (rst_n),
        .run_req_i       (run_req),
        .step_req_i      (step_req),
        .halt_detected_i (halt_det),
        .mem_busy_i      (mem_busy),
        .en_pipeline_o   (en_a),
        .state_o         (st_a),
        .halted_o        (hl_a),
        .step_done_o     (sd_a),
        .cycle_count_o   (cnt_a)
    );

    pipeline_ctrl #(
        .NB_CYCLES    (4),
        .DRAIN_CYCLES (0)
    ) u_dut_b (
        .clock_i         (clk),
        .reset_i         (rst_n),
        .run_req_i       (run_req),
        .step_req_i      (step_req),
        .halt_detected_i (halt_det),
        .mem_busy_i      (mem_busy),
        .en_pipeline_o   (en_b),
        .state_o         (st_b),
        .halted_o        (hl_b),
        .step_done_o     (sd_b),
        .cycle_count_o   (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PIPE_CTRL_CYCLE_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    // Model: mode 0 idle, 1 running, 2 single step, 3 draining, 4 halted
    typedef struct {
        int     mode;
        int     left;
        bit     done;
        longint adv;
    } mdl_t;

    typedef struct {
        bit          en_a;
        logic [2:0]  st_a;
        bit          hl_a;
        bit          sd_a;
        logic [31:0] cnt_a;
        bit          en_b;
        logic [2:0]  st_b;
        bit          hl_b;
        bit          sd_b;
        logic [3:0]  cnt_b;
    } exp_t;

    exp_t exp_q[$];
    mdl_t ma;
    mdl_t mb;
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.mode = 0;
        m.left = 0;
        m.done = 1'b0;
        m.adv  = 0;
        return m;
    endfunction

    function automatic bit mdl_adv(mdl_t m, bit busy);
        return (m.mode >= 1) && (m.mode <= 3) && !busy;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, bit rst, bit run, bit step,
                                      bit halt, bit busy, int dc);
        mdl_t n;
        bit   adv;
        if (!rst) return mdl_reset();
        n      = m;
        n.done = 1'b0;
        adv    = mdl_adv(m, busy);
        if (adv) n.adv = m.adv + 1;
        if (m.mode == 0) begin
            if (run) n.mode = 1;
            else if (step) n.mode = 2;
        end else if (m.mode == 1 || m.mode == 2) begin
            if (adv && halt) begin
                n.mode = 3;
                n.left = (dc < 1) ? 1 : dc;
            end else if (adv && m.mode == 2) begin
                n.mode = 0;
                n.done = 1'b1;
            end
        end else if (m.mode == 3) begin
            if (adv) begin
                n.left = m.left - 1;
                if (n.left == 0) n.mode = 4;
            end
        end
        return n;
    endfunction

    function automatic longint sat(longint v, longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic cyc(input bit rst, input bit run, input bit step,
                       input bit halt, input bit busy);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n    = rst;
        run_req  = run;
        step_req = step;
        halt_det = halt;
        mem_busy = busy;
        e.en_a  = mdl_adv(ma, busy);
        e.st_a  = 3'(ma.mode);
        e.hl_a  = (ma.mode == 4);
        e.sd_a  = ma.done;
        e.cnt_a = CNT_ON ? 32'(sat(ma.adv, 64'hFFFF_FFFF)) : 32'd0;
        e.en_b  = mdl_adv(mb, busy);
        e.st_b  = 3'(mb.mode);
        e.hl_b  = (mb.mode == 4);
        e.sd_b  = mb.done;
        e.cnt_b = CNT_ON ? 4'(sat(mb.adv, 15)) : 4'd0;
        exp_q.push_back(e);
        ma = mdl_step(ma, rst, run, step, halt, busy, 4);
        mb = mdl_step(mb, rst, run, step, halt, busy, 0);
    endtask

    task automatic idle_n(input int n, input bit busy);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, busy);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     nm, cyc_no, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cyc_no++;
                chk("en_a",   32'(en_a),  32'(e.en_a));
                chk("state_a",32'(st_a),  32'(e.st_a));
                chk("halt_a", 32'(hl_a),  32'(e.hl_a));
                chk("sdone_a",32'(sd_a),  32'(e.sd_a));
                chk("count_a",cnt_a,      e.cnt_a);
                chk("en_b",   32'(en_b),  32'(e.en_b));
                chk("state_b",32'(st_b),  32'(e.st_b));
                chk("halt_b", 32'(hl_b),  32'(e.hl_b));
                chk("sdone_b",32'(sd_b),  32'(e.sd_b));
                chk("count_b",32'(cnt_b), 32'(e.cnt_b));
            end
        end
    end

    initial begin : stim
        rst_n    = 1'b0;
        run_req  = 1'b0;
        step_req = 1'b0;
        halt_det = 1'b0;
        mem_busy = 1'b0;
        @(posedge clk);
        ma = mdl_reset();
        mb = mdl_reset();
        cyc(0, 0, 0, 0, 0);
        idle_n(2, 0);

        // single step, no stall
        cyc(1, 0, 1, 0, 0);
        idle_n(3, 0);

        // single step held by memory for three cycles
        cyc(1, 0, 1, 0, 0);
        idle_n(3, 1);
        idle_n(3, 0);

        // simultaneous run and step, then abort by reset
        cyc(1, 1, 1, 0, 0);
        idle_n(5, 0);
        cyc(0, 0, 0, 0, 0);
        idle_n(1, 0);

        // run, halt on the 10th advancing cycle, drain, halted
        cyc(1, 1, 0, 0, 0);
        idle_n(9, 0);
        cyc(1, 0, 0, 1, 0);
        idle_n(4, 0);
        cyc(1, 1, 1, 1, 0);
        idle_n(3, 0);
        cyc(0, 0, 0, 0, 0);

        // reset while draining with two cycles left, then restart
        cyc(1, 1, 0, 0, 0);
        idle_n(2, 0);
        cyc(1, 0, 0, 1, 0);
        idle_n(2, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        idle_n(3, 0);

        // halt ignored under stall; step halting into drain
        cyc(1, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 1);
        cyc(1, 0, 0, 1, 0);
        idle_n(6, 0);
        cyc(0, 0, 0, 0, 0);

        // long run for counter saturation
        cyc(1, 1, 0, 0, 0);
        idle_n(22, 0);
        cyc(0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(63) != 0),
                ($urandom_range(15) == 0),
                ($urandom_range(9) == 0),
                ($urandom_range(7) == 0),
                ($urandom_range(2) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter NB_CYCLES, default 32: width of the cycle counter output.
REQ-002 Parameter DRAIN_CYCLES, default 4: advancing cycles allowed after halt detection so the halt instruction reaches write-back.
REQ-003 clock_i  input  1  single clock; all state updates on posedge clock_i.
REQ-004 reset_i  input  1  reset; synchronous and active-low.
REQ-005 run_req_i  input  1  one-cycle pulse requesting continuous execution.
REQ-006 step_req_i  input  1  one-cycle pulse requesting a single pipeline advance.
REQ-007 halt_detected_i  input  1  halt instruction present in the pipeline, from ID stage.
REQ-008 mem_busy_i  input  1  memory stall request; the pipeline holds while high.
REQ-009 en_pipeline_o  output  1  enable to every stage register, including the EX/MEM register.
REQ-010 state_o  output  3  current FSM state encoding.
REQ-011 halted_o  output  1  high while in HALTED.
REQ-012 step_done_o  output  1  one-cycle pulse after a completed step.
REQ-013 cycle_count_o  output  NB_CYCLES  count of advancing cycles.

Function
REQ-014 States and encodings: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4.
REQ-015 en_pipeline_o is combinational: 1 iff the state is RUN, STEP or DRAIN and mem_busy_i=0.
REQ-016 An advancing cycle is any cycle with en_pipeline_o=1.
REQ-017 IDLE transitions:
  - run_req_i -> RUN.
  - else step_req_i -> STEP.
  - run_req_i and step_req_i together -> RUN.
REQ-018 RUN transitions:
  - halt_detected_i during an advancing cycle -> DRAIN, with the drain counter loaded to DRAIN_CYCLES.
  - otherwise stay in RUN.
  - run_req_i and step_req_i are ignored.
REQ-019 STEP transitions:
  - On the first advancing cycle -> IDLE, and step_done_o pulses the following cycle.
  - If halt_detected_i is high on that cycle -> DRAIN instead, with no step_done_o.
  - While mem_busy_i=1, remain in STEP.
REQ-020 DRAIN: decrement the drain counter on each advancing cycle; on the advancing cycle where the counter equals 1, next state is HALTED.
REQ-021 DRAIN_CYCLES=0 is treated as 1.
REQ-022 HALTED: en_pipeline_o=0 and halted_o=1; all requests are ignored; HALTED is left only by reset.
REQ-023 halt_detected_i is ignored in IDLE, DRAIN and HALTED, and in any cycle with mem_busy_i=1.
REQ-024 Request pulses that arrive while not in IDLE are dropped, not queued.
REQ-025 Latency: a request sampled at posedge N produces the new state, and en_pipeline_o (if mem_busy_i=0), from posedge N onward.
REQ-026 cycle_count_o increments by 1 per advancing cycle and saturates at all-ones.

Reset
REQ-027 While reset_i=0 at a posedge, the block SHALL clear:
  - state to IDLE;
  - drain counter to 0;
  - step_done_o to 0;
  - cycle_count_o to 0.
REQ-028 Consequently en_pipeline_o=0 and halted_o=0 during and after reset.
REQ-029 Reset asserted mid-RUN, mid-STEP or mid-DRAIN aborts the operation with no step_done_o pulse.

Configuration
REQ-030 Macro PIPE_CTRL_CYCLE_CNT_EN: when defined, the cycle counter is present as specified in REQ-026.
REQ-031 When PIPE_CTRL_CYCLE_CNT_EN is undefined, cycle_count_o is constant 0 and no counter flops exist.

Structure
REQ-032 The shared package pipeline_ctrl_pkg SHALL hold:
  - the state encodings IDLE..HALTED;
  - the state width (3);
  - the DRAIN_CYCLES default.
REQ-033 The saturating counter SHALL be a sub-module named pipe_cycle_counter, with ports clock, reset, enable and count, instantiated only under PIPE_CTRL_CYCLE_CNT_EN.
REQ-034 The FSM and drain counter stay in pipeline_ctrl.

Verification
REQ-035 Step: reset, then step_req_i pulse with mem_busy_i=0 -> en_pipeline_o high exactly 1 cycle, step_done_o pulses the next cycle, state_o returns to 0, cycle_count_o=1.
REQ-036 Step with stall: step_req_i pulse with mem_busy_i=1 for 3 cycles -> en_pipeline_o stays 0 for those 3 cycles, then is high exactly 1 cycle, then step_done_o pulses.
REQ-037 Run to halt: run_req_i pulse, then halt_detected_i on the 10th advancing cycle with DRAIN_CYCLES=4 -> 4 further advancing cycles, then halted_o=1, en_pipeline_o=0, cycle_count_o=14.
REQ-038 Simultaneous requests: run_req_i and step_req_i in the same cycle from IDLE -> state_o=1, and no step_done_o ever pulses.
REQ-039 Reset abort: reset_i=0 during DRAIN (counter=2) -> next cycle state_o=0, cycle_count_o=0, halted_o=0; the following run_req_i restarts normally.
REQ-040 Saturation: with NB_CYCLES=4 and the macro defined, 20 advancing cycles -> cycle_count_o=15; with the macro undefined, cycle_count_o=0 throughout.
